// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues in-order word reads from the
//                fetch PC under a credit limit, tags each request with its PC,
//                queues returned words with their PCs for the decoder, and
//                flushes/squashes on redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    // Stale responses can pile up across back-to-back redirects, so the
    // discard counter gets headroom beyond one queue's worth.
    localparam int c_DIS_W = c_CNT_W + 4;
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(QUEUE_DEPTH);

    logic                 r_started;
    logic [31:0]          r_fetch_pc;
    logic [c_CNT_W-1:0]   r_inflight;
    logic [c_DIS_W-1:0]   r_discard;

    logic [31:0]          r_tag_mem [QUEUE_DEPTH];
    logic [c_PTR_W-1:0]   r_tag_wr;
    logic [c_PTR_W-1:0]   r_tag_rd;

    logic [31:0]          r_q_pc    [QUEUE_DEPTH];
    logic [31:0]          r_q_instr [QUEUE_DEPTH];
    logic [c_PTR_W-1:0]   r_q_wr;
    logic [c_PTR_W-1:0]   r_q_rd;
    logic [c_CNT_W-1:0]   r_q_count;

    logic [c_CNT_W:0]     w_occupancy;
    logic                 w_credit;
    logic                 w_fire;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;

    // Credit covers both queued words and requests still out at memory, so
    // every response is guaranteed a queue slot.
    assign w_occupancy    = {1'b0, r_inflight} + {1'b0, r_q_count};
    assign w_credit       = (w_occupancy < c_DEPTH);
    assign imem_req_valid = !rst && !redirect && r_started && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    assign w_drop = imem_resp_valid && (r_discard != '0);
    assign w_push = imem_resp_valid && (r_discard == '0);

    assign out_valid = (r_q_count != '0);
    assign out_pc    = r_q_pc[r_q_rd];
    assign out_instr = r_q_instr[r_q_rd];
    assign w_pop     = out_valid && out_ready;

    // Control state: PC, credit/discard counters, FIFO pointers; redirect flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_started  <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_q_wr     <= '0;
            r_q_rd     <= '0;
            r_q_count  <= '0;
        end else begin
            r_started <= 1'b1;
            if (redirect) begin
                r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                // Everything still out becomes stale; a response landing this
                // cycle is already accounted for.
                r_discard  <= r_discard + c_DIS_W'(r_inflight)
                              - c_DIS_W'(imem_resp_valid);
                r_inflight <= '0;
                r_tag_wr   <= '0;
                r_tag_rd   <= '0;
                r_q_wr     <= '0;
                r_q_rd     <= '0;
                r_q_count  <= '0;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_tag_wr   <= r_tag_wr + 1'b1;
                end
                if (w_push) begin
                    r_tag_rd <= r_tag_rd + 1'b1;
                    r_q_wr   <= r_q_wr + 1'b1;
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + 1'b1;
                end
                if (w_drop) begin
                    r_discard <= r_discard - 1'b1;
                end
                r_inflight <= r_inflight + c_CNT_W'(w_fire) - c_CNT_W'(w_push);
                r_q_count  <= r_q_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
        end
    end

    // Storage arrays: validity is tracked by the pointers/counts above.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_tag_mem[r_tag_wr] <= r_fetch_pc;
        end
        if (w_push && !redirect && !rst) begin
            r_q_pc[r_q_wr]    <= r_tag_mem[r_tag_rd];
            r_q_instr[r_q_wr] <= imem_resp_data;
        end
    end

    a_resp_expected: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> ((r_inflight != '0) || (r_discard != '0)));

    a_queue_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, r_q_count} <= c_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a fixed-latency
//                in-order memory model and a PC-stream scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    logic        d2_req_valid;
    logic [31:0] d2_req_addr;
    logic        d2_out_valid;
    logic [31:0] d2_out_instr;
    logic [31:0] d2_out_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    // Second instance only observes address wrap from a high reset PC.
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(d2_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(d2_req_addr),
        .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
        .redirect(1'b0), .redirect_pc(32'h0),
        .out_valid(d2_out_valid), .out_instr(d2_out_instr), .out_pc(d2_out_pc),
        .out_ready(1'b0)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pending[$];
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    int          n_req = 0;
    int          n_out = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    // Memory model: in-order, fixed latency, one response per cycle.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pending.delete();
                imem_resp_valid = 1'b0;
            end else begin
                if (imem_resp_valid && pending.size() > 0) void'(pending.pop_front());
                cyc++;
                if (pending.size() > 0 && pending[0].due <= cyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = memword(pending[0].addr);
                end else begin
                    imem_resp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: request ordering/stability and output stream scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall && !redirect) begin
                    check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
                    check("req_hold_addr", imem_req_addr, prev_addr);
                end
                prev_stall = imem_req_valid && !imem_req_ready;
                prev_addr  = imem_req_addr;
                if (imem_req_valid && imem_req_ready) begin
                    pending.push_back('{addr: imem_req_addr, due: cyc + lat});
                    check("req_addr", imem_req_addr, exp_addr);
                    exp_addr = exp_addr + 32'd4;
                    n_req++;
                end
                if (out_valid && out_ready) begin
                    check("out_pc", out_pc, exp_pc);
                    check("out_instr", out_instr, memword(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    n_out++;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [31:0] start);
        rst = 1'b1;
        redirect = 1'b0;
        out_ready = 1'b0;
        imem_req_ready = 1'b1;
        step(1);
        @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        step(1);
        exp_addr = start;
        exp_pc   = start;
        n_req    = 0;
        n_out    = 0;
        rst      = 1'b0;
    endtask

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
    } redir_vec_t;

    redir_vec_t vecs[5];

    initial begin
        vecs[0] = '{rpc: 32'h0000_0103, exp_addr: 32'h0000_0100};
        vecs[1] = '{rpc: 32'h0000_0002, exp_addr: 32'h0000_0000};
        vecs[2] = '{rpc: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC};
        vecs[3] = '{rpc: 32'h1234_5679, exp_addr: 32'h1234_5678};
        vecs[4] = '{rpc: 32'h0000_0040, exp_addr: 32'h0000_0040};

        // Streaming at latency 1, plus wrap from the high reset PC on dut2.
        do_reset(32'h0);
        lat = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t1_req_valid", {31'b0, imem_req_valid}, (i >= 1) ? 32'd1 : 32'd0);
            check("t1_out_valid", {31'b0, out_valid}, (i >= 3) ? 32'd1 : 32'd0);
            check("t5_wrap_valid", {31'b0, d2_req_valid}, (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= 4)
                check("t5_wrap_addr", d2_req_addr, 32'hFFFF_FFF8 + 32'(4 * (i - 1)));
            step(1);
        end
        check("t1_count", n_out, 32'd17);

        // Decoder stalled: credit stops fetch at a full queue, then drains.
        do_reset(32'h0);
        lat = 1;
        out_ready = 1'b0;
        step(10);
        @(negedge clk);
        check("t2_req_count", n_req, 32'd4);
        check("t2_req_stopped", {31'b0, imem_req_valid}, 32'd0);
        check("t2_head_pc", out_pc, 32'h0);
        step(1);
        out_ready = 1'b1;
        step(12);
        check("t2_drain", {31'b0, n_out >= 8}, 32'd1);

        // Redirect with two requests in flight at latency 3.
        do_reset(32'h0);
        lat = 3;
        out_ready = 1'b1;
        step(3);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        check("t3_inflight", n_req, 32'd2);
        check("t3_no_req", {31'b0, imem_req_valid}, 32'd0);
        step(1);
        redirect = 1'b0;
        exp_addr = 32'h100;
        exp_pc   = 32'h100;
        n_out    = 0;
        step(12);
        check("t3_progress", {31'b0, n_out >= 1}, 32'd1);

        // Redirect coinciding with a pop and a response.
        do_reset(32'h0);
        lat = 1;
        out_ready = 1'b1;
        step(6);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check("t4_pop_present", {31'b0, out_valid}, 32'd1);
        check("t4_resp_present", {31'b0, imem_resp_valid}, 32'd1);
        check("t4_no_req", {31'b0, imem_req_valid}, 32'd0);
        step(1);
        redirect = 1'b0;
        exp_addr = 32'h200;
        exp_pc   = 32'h200;
        @(negedge clk);
        check("t4_flushed", {31'b0, out_valid}, 32'd0);
        check("t4_new_req", {31'b0, imem_req_valid}, 32'd1);
        step(1);
        @(negedge clk);
        check("t4_still_empty", {31'b0, out_valid}, 32'd0);
        step(1);
        @(negedge clk);
        check("t4_first_valid", {31'b0, out_valid}, 32'd1);
        check("t4_first_pc", out_pc, 32'h200);

        // Table-driven redirect targets (alignment and wrap) at latency 2.
        lat = 2;
        for (int v = 0; v < 5; v++) begin
            step(1);
            redirect = 1'b1;
            redirect_pc = vecs[v].rpc;
            step(1);
            redirect = 1'b0;
            exp_addr = vecs[v].exp_addr;
            exp_pc   = vecs[v].exp_addr;
            @(negedge clk);
            check("tv_req_valid", {31'b0, imem_req_valid}, 32'd1);
            check("tv_req_addr", imem_req_addr, vecs[v].exp_addr);
            check("tv_out_empty", {31'b0, out_valid}, 32'd0);
            step(6);
        end

        // Random memory/decoder backpressure over a long stream.
        do_reset(32'h0);
        lat = 2;
        for (int c = 0; c < 8000 && n_out < 1000; c++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            step(1);
        end
        check("t6_count", {31'b0, n_out >= 1000}, 32'd1);
        check("d2_out_idle", {31'b0, d2_out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
